state_screen_renderer: RTL and testbench

- Consumer of the 4-bit drawing state produced by the drawing-state controller.
- Generates 640x480 VGA raster timing and selects the pixel colour per drawing state: credentials screen, time-entry screen, game layer pass-through, and player-dead screen.
- Applies state changes only at frame boundaries, with a programmable number of black frames between screens, so no frame ever shows a mix of two screens.
- Sits between the state controller/game renderer and the VGA DAC pins.

---
 rtl/state_screen_renderer_pkg.sv | 31 +++
 rtl/state_screen_renderer_vga_raster_counter.sv | 75 +++++++
 rtl/state_screen_renderer.sv | 163 ++++++++++++++++
 tb/tb_state_screen_renderer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/state_screen_renderer_pkg.sv
// Shared constants for the state screen renderer: drawing states, RGB332 palette,
// default 640x480 VGA timing and the blanking FSM encoding.
package state_screen_renderer_pkg;

    localparam logic [3:0] ST_CREDENTIALS = 4'd1;
    localparam logic [3:0] ST_TIME        = 4'd2;
    localparam logic [3:0] ST_GAME        = 4'd3;
    localparam logic [3:0] ST_DEAD        = 4'd4;

    localparam logic [7:0] RGB_WHITE = 8'hFF;
    localparam logic [7:0] RGB_BLUE  = 8'h03;
    localparam logic [7:0] RGB_GREEN = 8'h1C;
    localparam logic [7:0] RGB_RED   = 8'hE0;
    localparam logic [7:0] RGB_GRAY  = 8'h92;
    localparam logic [7:0] RGB_BLACK = 8'h00;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    typedef enum logic {
        FSM_SHOW  = 1'b0,
        FSM_BLANK = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/state_screen_renderer_vga_raster_counter.sv
// VGA raster position counters with combinational sync/active decode and a
// frame_start pulse on the first pixel tick of each new frame.
module vga_raster_counter
    import state_screen_renderer_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       active,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       wrap_q, wrap_d;

    // wrap_q marks "sitting at 0,0 because the raster wrapped"; it holds until the
    // next pixel tick so frame_start lands on a pix_en cycle even when pix_en is sparse.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        wrap_d = wrap_q;
        if (pix_en) begin
            wrap_d = (x_q == H_LAST) && (y_q == V_LAST);
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            wrap_q <= wrap_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync_n     = !((x_q >= HS_START) && (x_q < HS_END));
    assign vsync_n     = !((y_q >= VS_START) && (y_q < VS_END));
    assign active      = (x_q < H_ACT) && (y_q < V_ACT);
    assign frame_start = wrap_q & pix_en;

endmodule

// File: rtl/state_screen_renderer.sv
// Selects a per-state screen colour on top of VGA raster timing, switching screens
// only on frame boundaries with optional black frames in between.
module state_screen_renderer
    import state_screen_renderer_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
    parameter int unsigned H_FP         = VGA_H_FP,
    parameter int unsigned H_SYNC       = VGA_H_SYNC,
    parameter int unsigned H_BP         = VGA_H_BP,
    parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
    parameter int unsigned V_FP         = VGA_V_FP,
    parameter int unsigned V_SYNC       = VGA_V_SYNC,
    parameter int unsigned V_BP         = VGA_V_BP,
    parameter int unsigned BLANK_FRAMES = 2,
    parameter int unsigned BORDER       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic [3:0] drawing_state,
    input  logic [7:0] game_pixel,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [7:0] rgb,
    output logic [3:0] shown_state,
    output logic       frame_start
);

    localparam logic [7:0] BLANK_INIT = 8'(BLANK_FRAMES);
    localparam logic [9:0] BORDER_W   = 10'(BORDER);
    localparam logic [9:0] BORDER_R   = 10'(H_ACTIVE - BORDER);
    localparam logic [9:0] BORDER_B   = 10'(V_ACTIVE - BORDER);

    logic [9:0] ras_x, ras_y;
    logic       ras_hsync_n, ras_vsync_n, ras_active, ras_frame_start;
    logic       in_border;

    fsm_state_e state_q, state_d;
    logic [3:0] shown_q, shown_d;
    logic [3:0] target_q, target_d;
    logic [7:0] blank_cnt_q, blank_cnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic [7:0] rgb_q, rgb_d;

    vga_raster_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_raster (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .x           (ras_x),
        .y           (ras_y),
        .hsync_n     (ras_hsync_n),
        .vsync_n     (ras_vsync_n),
        .active      (ras_active),
        .frame_start (ras_frame_start)
    );

    function automatic logic [7:0] screen_colour(input logic [3:0] st, input logic border,
                                                 input logic [7:0] game);
        case (st)
            ST_CREDENTIALS: screen_colour = border ? RGB_WHITE : RGB_BLUE;
            ST_TIME:        screen_colour = border ? RGB_WHITE : RGB_GREEN;
            ST_GAME:        screen_colour = game;
            ST_DEAD:        screen_colour = border ? RGB_WHITE : RGB_RED;
            default:        screen_colour = RGB_GRAY;
        endcase
    endfunction

    assign in_border = (ras_x < BORDER_W) || (ras_x >= BORDER_R) ||
                       (ras_y < BORDER_W) || (ras_y >= BORDER_B);

    always_comb begin
        state_d     = state_q;
        shown_d     = shown_q;
        target_d    = target_q;
        blank_cnt_d = blank_cnt_q;
        if (ras_frame_start) begin
            case (state_q)
                FSM_SHOW: begin
                    if (drawing_state != shown_q) begin
                        if (BLANK_FRAMES == 0) begin
                            shown_d = drawing_state;
                        end else begin
                            target_d    = drawing_state;
                            blank_cnt_d = BLANK_INIT;
                            state_d     = FSM_BLANK;
                        end
                    end
                end
                FSM_BLANK: begin
                    if (drawing_state != target_q) begin
                        target_d    = drawing_state;
                        blank_cnt_d = BLANK_INIT;
                    end else if (blank_cnt_q == 8'd1) begin
                        shown_d = target_q;
                        state_d = FSM_SHOW;
                    end else begin
                        blank_cnt_d = blank_cnt_q - 8'd1;
                    end
                end
                default: state_d = FSM_SHOW;
            endcase
        end
    end

    // Pixel 0,0 is coloured on the same tick the FSM updates, so use the next-state
    // view; otherwise the first pixel of a frame would belong to the previous screen.
    always_comb begin
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        video_on_d = video_on_q;
        rgb_d      = rgb_q;
        if (pix_en) begin
            hsync_d    = ras_hsync_n;
            vsync_d    = ras_vsync_n;
            video_on_d = ras_active;
            if (!ras_active || state_d == FSM_BLANK) begin
                rgb_d = RGB_BLACK;
            end else begin
                rgb_d = screen_colour(shown_d, in_border, game_pixel);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FSM_SHOW;
            shown_q     <= ST_CREDENTIALS;
            target_q    <= ST_CREDENTIALS;
            blank_cnt_q <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            video_on_q  <= 1'b0;
            rgb_q       <= RGB_BLACK;
        end else begin
            state_q     <= state_d;
            shown_q     <= shown_d;
            target_q    <= target_d;
            blank_cnt_q <= blank_cnt_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            video_on_q  <= video_on_d;
            rgb_q       <= rgb_d;
        end
    end

    assign x           = ras_x;
    assign y           = ras_y;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign rgb         = rgb_q;
    assign shown_state = shown_q;
    assign frame_start = ras_frame_start;

endmodule

// File: tb/tb_state_screen_renderer.sv
// Directed bench for state_screen_renderer using a reduced raster (56x37 total,
// 40x30 active, border 4) so several full frames fit in a short run.
module tb_state_screen_renderer;

    localparam int HA = 40, HF = 4, HS = 6, HB = 6;
    localparam int VA = 30, VF = 2, VS = 2, VB = 3;
    localparam int BRD = 4;
    localparam int HT = 56, VT = 37, FRAME = 2072;
    localparam int ACT = 1200, INTERIOR = 704;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_en;
    logic [3:0] drawing_state, drawing_state_b;
    logic [7:0] game_pixel;

    logic [9:0] x, y, x_b, y_b;
    logic       hsync, vsync, video_on, frame_start;
    logic       hsync_b, vsync_b, video_on_b, frame_start_b;
    logic [7:0] rgb, rgb_b;
    logic [3:0] shown_state, shown_state_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    state_screen_renderer #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .BLANK_FRAMES (2), .BORDER (BRD)
    ) dut (
        .clk (clk), .rst_n (rst_n), .pix_en (pix_en), .drawing_state (drawing_state),
        .game_pixel (game_pixel), .x (x), .y (y), .hsync (hsync), .vsync (vsync),
        .video_on (video_on), .rgb (rgb), .shown_state (shown_state),
        .frame_start (frame_start)
    );

    state_screen_renderer #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .BLANK_FRAMES (0), .BORDER (BRD)
    ) dut0 (
        .clk (clk), .rst_n (rst_n), .pix_en (pix_en), .drawing_state (drawing_state_b),
        .game_pixel (game_pixel), .x (x_b), .y (y_b), .hsync (hsync_b), .vsync (vsync_b),
        .video_on (video_on_b), .rgb (rgb_b), .shown_state (shown_state_b),
        .frame_start (frame_start_b)
    );

    // Move to the negedge where the raster sits at (px,py); slow mode drives pix_en 1-in-4.
    task automatic goto(input int px, input int py, input bit slow, output bit ok);
        int phase = 0;
        ok = 1'b0;
        for (int i = 0; i < 4 * FRAME + 8; i++) begin
            @(negedge clk);
            if (int'(x) == px && int'(y) == py) begin
                ok = 1'b1;
                break;
            end
            if (slow) begin
                pix_en = (phase % 4 == 3);
                phase++;
            end
        end
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // From a frame_start negedge, observe one whole frame of registered pixels and stop
    // on the next frame_start negedge.
    task automatic scan_frame(input bit use_b, input logic [7:0] val,
                              output int von, output int blk, output int eq);
        logic       v;
        logic [7:0] c;
        von = 0; blk = 0; eq = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            v = use_b ? video_on_b : video_on;
            c = use_b ? rgb_b : rgb;
            if (v) begin
                von++;
                if (c == 8'h00) blk++;
                if (c == val) eq++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1; pix_en = 1'b1; drawing_state = 4'd1; drawing_state_b = 4'd1;
        game_pixel = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (x !== 10'd0 || y !== 10'd0) begin errors++;
            $display("FAIL reset_xy: x=%0d y=%0d, required 0 0", x, y); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++;
            $display("FAIL reset_sync: hsync=%b vsync=%b, required 1 1", hsync, vsync); end
        checks++; if (video_on !== 1'b0 || rgb !== 8'h00) begin errors++;
            $display("FAIL reset_pixel: video_on=%b rgb=%h, required 0 00", video_on, rgb); end
        checks++; if (shown_state !== 4'd1 || frame_start !== 1'b0) begin errors++;
            $display("FAIL reset_state: shown=%0d fs=%b, required 1 0", shown_state, frame_start); end
        rst_n = 1'b1;
    endtask

    task automatic test_raster_timing;
        int first_fs = -1, hcnt = 0, vcnt = 0, h_first = -1, v_first = -1;
        int px = 0, py = 0;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            @(negedge clk);
            if (!hsync) begin hcnt++; if (h_first < 0) h_first = px; end
            if (!vsync) begin vcnt++; if (v_first < 0) v_first = py; end
            px = int'(x); py = int'(y);
            if (frame_start) begin first_fs = i; break; end
        end
        checks++; if (first_fs != FRAME) begin errors++;
            $display("FAIL first_frame_start: at clock %0d, required %0d", first_fs, FRAME); end
        checks++; if (hcnt != HS * VT) begin errors++;
            $display("FAIL hsync_low_ticks: %0d, required %0d", hcnt, HS * VT); end
        checks++; if (h_first != HA + HF) begin errors++;
            $display("FAIL hsync_start_x: %0d, required %0d", h_first, HA + HF); end
        checks++; if (vcnt != VS * HT) begin errors++;
            $display("FAIL vsync_low_ticks: %0d, required %0d", vcnt, VS * HT); end
        checks++; if (v_first != VA + VF) begin errors++;
            $display("FAIL vsync_start_y: %0d, required %0d", v_first, VA + VF); end
    endtask

    task automatic test_pixels;
        bit ok;
        int px[5] = '{20, 2, 38, 20, 45};
        int py[5] = '{15, 15, 15, 1, 15};
        logic [7:0] exp_rgb[5] = '{8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        logic       exp_von[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            goto(px[k], py[k], 1'b0, ok);
            @(negedge clk);
            checks++;
            if (!ok || rgb !== exp_rgb[k] || video_on !== exp_von[k]) begin errors++;
                $display("FAIL pixel_%0d_%0d: found=%b von=%b rgb=%h, required von=%b rgb=%h",
                         px[k], py[k], ok, video_on, rgb, exp_von[k], exp_rgb[k]);
            end
        end
    endtask

    task automatic test_blank_switch;
        bit ok;
        int von, blk, eq;
        goto(20, 15, 1'b0, ok);
        drawing_state = 4'd3; game_pixel = 8'h5A;
        goto(20, 20, 1'b0, ok);
        @(negedge clk);
        checks++; if (!ok || rgb !== 8'h03 || shown_state !== 4'd1) begin errors++;
            $display("FAIL frame_unchanged: rgb=%h shown=%0d, required 03 1", rgb, shown_state); end
        wait_fs(ok);
        checks++; if (!ok || shown_state !== 4'd1) begin errors++;
            $display("FAIL f1_shown: found=%b shown=%0d, required 1", ok, shown_state); end
        for (int f = 0; f < 2; f++) begin
            scan_frame(1'b0, 8'h00, von, blk, eq);
            checks++; if (von != ACT || blk != ACT || shown_state !== 4'd1) begin errors++;
                $display("FAIL blank_frame_%0d: von=%0d black=%0d shown=%0d, required %0d %0d 1",
                         f, von, blk, shown_state, ACT, ACT); end
        end
        scan_frame(1'b0, 8'h5A, von, blk, eq);
        checks++; if (eq != ACT || shown_state !== 4'd3) begin errors++;
            $display("FAIL game_frame: game_pixels=%0d shown=%0d, required %0d 3", eq, shown_state, ACT); end
    endtask

    task automatic test_blank_reload;
        bit ok;
        int von, blk, eq;
        @(negedge clk);
        drawing_state = 4'd1;
        wait_fs(ok);
        @(negedge clk);
        checks++; if (!ok || video_on !== 1'b1 || rgb !== 8'h00) begin errors++;
            $display("FAIL blank_begins: von=%b rgb=%h, required 1 00", video_on, rgb); end
        drawing_state = 4'd4;
        wait_fs(ok);
        for (int f = 0; f < 2; f++) begin
            scan_frame(1'b0, 8'h00, von, blk, eq);
            checks++; if (!ok || blk != ACT || shown_state !== 4'd3) begin errors++;
                $display("FAIL reload_blank_%0d: black=%0d shown=%0d, required %0d 3",
                         f, blk, shown_state, ACT); end
        end
        scan_frame(1'b0, 8'hE0, von, blk, eq);
        checks++; if (eq != INTERIOR || blk != 0 || shown_state !== 4'd4) begin errors++;
            $display("FAIL dead_frame: red=%0d black=%0d shown=%0d, required %0d 0 4",
                     eq, blk, shown_state, INTERIOR); end
    endtask

    task automatic test_no_blank;
        bit ok;
        int von, blk, eq;
        @(negedge clk);
        drawing_state_b = 4'd7;
        wait_fs(ok);
        checks++; if (!ok || shown_state_b !== 4'd1) begin errors++;
            $display("FAIL nb_before: shown=%0d, required 1", shown_state_b); end
        scan_frame(1'b1, 8'h92, von, blk, eq);
        checks++; if (eq != ACT || shown_state_b !== 4'd7) begin errors++;
            $display("FAIL nb_gray_frame: gray=%0d shown=%0d, required %0d 7", eq, shown_state_b, ACT); end
    endtask

    task automatic test_slow_and_reset;
        bit ok, p;
        int bad = 0, moves = 0, prev_x, prev_y, ex, ey;
        @(negedge clk);
        pix_en = 1'b0; p = 1'b0;
        prev_x = int'(x); prev_y = int'(y);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            ex = prev_x; ey = prev_y;
            if (p) begin
                moves++;
                ex = prev_x + 1;
                if (ex == HT) begin ex = 0; ey = (prev_y + 1 == VT) ? 0 : prev_y + 1; end
            end
            if (int'(x) != ex || int'(y) != ey) bad++;
            prev_x = int'(x); prev_y = int'(y);
            p = (i % 4 == 3);
            pix_en = p;
        end
        checks++; if (bad != 0 || moves != 15) begin errors++;
            $display("FAIL slow_counters: wrong_steps=%0d moves=%0d, required 0 15", bad, moves); end
        goto(30, 20, 1'b1, ok);
        checks++; if (!ok || shown_state !== 4'd4) begin errors++;
            $display("FAIL reach_30_20: found=%b shown=%0d, required 1 4", ok, shown_state); end
        rst_n = 1'b0;
        #1;
        checks++; if (x !== 10'd0 || y !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1) begin errors++;
            $display("FAIL midreset_raster: x=%0d y=%0d hs=%b vs=%b, required 0 0 1 1", x, y, hsync, vsync); end
        checks++; if (video_on !== 1'b0 || rgb !== 8'h00 || shown_state !== 4'd1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: von=%b rgb=%h shown=%0d fs=%b, required 0 00 1 0",
                     video_on, rgb, shown_state, frame_start); end
        @(negedge clk);
        rst_n = 1'b1; pix_en = 1'b1;
        @(negedge clk);
        checks++; if (x !== 10'd1 || y !== 10'd0) begin errors++;
            $display("FAIL restart_xy: x=%0d y=%0d, required 1 0", x, y); end
    endtask

    initial begin
        test_reset();
        test_raster_timing();
        test_pixels();
        test_blank_switch();
        test_blank_reload();
        test_no_blank();
        test_slow_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
